// File: rtl/mips_pkg.sv
// Shared opcode, kind and FSM-state definitions for the MIPS instruction encoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] KIND_R    = 3'd0;
  localparam logic [2:0] KIND_LW   = 3'd1;
  localparam logic [2:0] KIND_SW   = 3'd2;
  localparam logic [2:0] KIND_BEQ  = 3'd3;
  localparam logic [2:0] KIND_ADDI = 3'd4;
  localparam logic [2:0] KIND_J    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_WR   = 2'd2
  } enc_state_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } instr_fields_t;

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational packer: field bundle -> 32-bit MIPS word plus legal flag.
// J-type (kind 5) is legal only when MIPS_ENC_JUMP_EN is defined.
module mips_instr_pack
  import mips_pkg::*;
(
  input  instr_fields_t fields,
  output logic [31:0]   word,
  output logic          legal
);

`ifndef MIPS_ENC_JUMP_EN
  logic unused_target;
  assign unused_target = ^fields.target;
`endif

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (fields.kind)
      KIND_R:    word = {OP_RTYPE, fields.rs, fields.rt, fields.rd, fields.shamt, fields.funct};
      KIND_LW:   word = i_type(OP_LW,   fields.rs, fields.rt, fields.imm);
      KIND_SW:   word = i_type(OP_SW,   fields.rs, fields.rt, fields.imm);
      KIND_BEQ:  word = i_type(OP_BEQ,  fields.rs, fields.rt, fields.imm);
      KIND_ADDI: word = i_type(OP_ADDI, fields.rs, fields.rt, fields.imm);
`ifdef MIPS_ENC_JUMP_EN
      KIND_J:    word = {OP_J, fields.target};
`endif
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Sequential instruction loader: accepts field bundles, packs them, and writes
// words to instruction memory from address 0. Optional macro: MIPS_ENC_JUMP_EN.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  enc_state_t    state, state_next;
  instr_fields_t fields_q;
  logic [31:0]   packed_word;
  logic          packed_legal;
  logic          accept;
  logic [ADDR_W:0] count_inc;

  mips_instr_pack u_pack (
    .fields (fields_q),
    .word   (packed_word),
    .legal  (packed_legal)
  );

  // rst_n gates in_ready so it reads 0 while reset is held, not just after it.
  assign in_ready  = rst_n & (state == ST_IDLE) & ~full & ~clear;
  assign accept    = in_valid & in_ready;
  assign imem_we   = (state == ST_WR) & ~clear;
  assign count_inc = count + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_next = ST_ENC;
        ST_ENC:  state_next = packed_legal ? ST_WR : ST_IDLE;
        ST_WR:   state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fields_q   <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else if (clear) begin
      imem_addr <= '0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            fields_q <= '{kind: kind, rs: rs, rt: rt, rd: rd, shamt: shamt,
                          funct: funct, imm: imm, target: target};
          end
        end
        ST_ENC: begin
          if (packed_legal) imem_wdata <= packed_word;
          else              err        <= 1'b1;
        end
        ST_WR: begin
          imem_addr <= imem_addr + 1'b1;
          count     <= count_inc;
          full      <= (count_inc == DEPTH_CNT);
        end
        default: ;
      endcase
    end
  end

endmodule
